mem_ctrl: RTL

Byte-serial memory controller that shares the single 8-bit RAM port between instruction fetch and the load/store buffer. It arbitrates between the two requesters, sequences 1/2/4-byte little-endian accesses one byte per cycle, and returns zero-extended load data; sign extension stays in the LSB. It also aborts speculative reads on `clear_all`, while committed stores always run to completion.

---
 rtl/mem_ctrl_if.sv | 35 +++
 rtl/mem_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: RAM port, LSB and IF request/response bundle for mem_ctrl.
interface mem_ctrl_if;
  logic        rdy_in;
  logic        io_buffer_full;
  logic        clear_all;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        go_work;
  logic        l_or_s;
  logic [2:0]  width;
  logic [31:0] address;
  logic [31:0] value_store;
  logic        received;
  logic        has_result;
  logic [31:0] value_load;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_grant;
  logic        if_done;
  logic [31:0] if_inst;
  modport master (
    output rdy_in, io_buffer_full, clear_all, mem_din, go_work, l_or_s, width,
           address, value_store, if_req, if_addr,
    input  mem_dout, mem_a, mem_wr, received, has_result, value_load,
           if_grant, if_done, if_inst
  );
  modport slave (
    input  rdy_in, io_buffer_full, clear_all, mem_din, go_work, l_or_s, width,
           address, value_store, if_req, if_addr,
    output mem_dout, mem_a, mem_wr, received, has_result, value_load,
           if_grant, if_done, if_inst
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating IF fetches and LSB loads/stores.
// MEMCTRL_IO_STALL_EN: hold store bytes aimed at I/O space while io_buffer_full is high.
module mem_ctrl (
  input logic      clk_in,
  input logic      rst_in,
  mem_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2;
  logic [1:0]  r_state;
  logic [2:0]  r_cnt, r_len, r_rx;
  logic        r_own_if, r_last_if, r_wr, r_recv, r_grant, r_res, r_done;
  logic [31:0] r_base, r_wdata, r_rdata, r_a;
  logic [7:0]  r_dout;
  logic        w_arb, w_pick_if, w_stall;
  logic [2:0]  w_len;
  logic [31:0] w_addr;
  always_comb begin
    w_arb     = r_state == S_IDLE && !r_recv && !r_grant && !bus.clear_all && (bus.go_work || bus.if_req);
    w_pick_if = bus.if_req && (!bus.go_work || !r_last_if);
    w_len     = w_pick_if ? 3'd4 : bus.width == 3'd1 ? 3'd1 : bus.width == 3'd2 ? 3'd2 : 3'd4;
    w_addr    = r_state == S_IDLE ? (w_pick_if ? bus.if_addr : bus.address) : r_base + {29'd0, r_cnt};
  end
`ifdef MEMCTRL_IO_STALL_EN
  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  assign w_stall = w_addr >= IO_BASE && bus.io_buffer_full;
`else
  assign w_stall = 1'b0;
`endif
  // r_cnt counts bytes issued; r_rx counts bytes captured, starting at -1 to skip the RAM latency edge
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_len     <= 3'd0;
      r_rx      <= 3'd0;
      r_own_if  <= 1'b0;
      r_last_if <= 1'b0;
      r_wr      <= 1'b0;
      r_recv    <= 1'b0;
      r_grant   <= 1'b0;
      r_res     <= 1'b0;
      r_done    <= 1'b0;
      r_base    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_a       <= 32'd0;
      r_dout    <= 8'd0;
    end else if (bus.rdy_in) begin
      r_recv  <= 1'b0;
      r_grant <= 1'b0;
      r_res   <= 1'b0;
      r_done  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_arb) begin
          r_recv    <= !w_pick_if;
          r_grant   <= w_pick_if;
          r_last_if <= w_pick_if;
          r_own_if  <= w_pick_if;
          r_base    <= w_addr;
          r_len     <= w_len;
          r_wdata   <= bus.value_store;
          r_rdata   <= 32'd0;
          r_rx      <= 3'd7;
          r_a       <= w_addr;
          r_dout    <= bus.value_store[7:0];
          if (!w_pick_if && bus.l_or_s) begin
            r_state <= S_WRITE;
            r_wr    <= !w_stall;
            r_cnt   <= w_stall ? 3'd0 : 3'd1;
          end else begin
            r_state <= S_READ;
            r_cnt   <= 3'd1;
          end
        end
      end else if (r_state == S_READ) begin
        if (bus.clear_all) begin
          r_state <= S_IDLE;
        end else begin
          if (r_cnt < r_len) begin
            r_a   <= w_addr;
            r_cnt <= r_cnt + 3'd1;
          end
          r_rx <= r_rx + 3'd1;
          if (r_rx != 3'd7) r_rdata[{r_rx[1:0], 3'b000} +: 8] <= bus.mem_din;
          if (r_rx == r_len - 3'd1) begin
            r_state <= S_IDLE;
            r_res   <= !r_own_if;
            r_done  <= r_own_if;
          end
        end
      end else if (r_cnt < r_len) begin
        r_wr <= !w_stall;
        if (!w_stall) begin
          r_a    <= w_addr;
          r_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
          r_cnt  <= r_cnt + 3'd1;
        end
      end else begin
        r_wr    <= 1'b0;
        r_state <= S_IDLE;
      end
    end
  end
  assign bus.mem_a      = r_a;
  assign bus.mem_dout   = r_dout;
  assign bus.mem_wr     = r_wr;
  assign bus.received   = r_recv;
  assign bus.if_grant   = r_grant;
  assign bus.has_result = r_res;
  assign bus.if_done    = r_done;
  assign bus.value_load = r_rdata;
  assign bus.if_inst    = r_rdata;
endmodule
